imem_loader: RTL and testbench

//  Boot-time program loader sitting directly upstream of the instruction (or data) bram32 write port.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_byte_word_packer.sv | 44 ++++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding and the byte/word geometry.
package imem_loader_pkg;

  localparam int LDR_STATE_W    = 3;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [LDR_STATE_W-1:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_LO = 3'd1,
    LDR_LEN_HI = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_WRITE  = 3'd4,
    LDR_DONE   = 3'd5
  } ldr_state_e;

  function automatic logic ldr_is_busy(input ldr_state_e s);
    return (s == LDR_LEN_LO) || (s == LDR_LEN_HI) ||
           (s == LDR_DATA)   || (s == LDR_WRITE);
  endfunction

  function automatic logic ldr_takes_bytes(input ldr_state_e s);
    return (s == LDR_LEN_LO) || (s == LDR_LEN_HI) || (s == LDR_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word.
// word_full_o is asserted combinationally alongside the 4th accepted byte.
module imem_loader_byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [WORD_W-BYTE_W-1:0] sh_q, sh_d;
  logic [1:0]               idx_q, idx_d;

  // Only the first three bytes are stored; the 4th is merged on the fly.
  assign word_o      = {byte_i, sh_q};
  assign word_full_o = byte_valid_i && (idx_q == 2'd3);

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (clear_i) begin
      sh_d  = '0;
      idx_d = '0;
    end else if (byte_valid_i) begin
      sh_d  = {byte_i, sh_q[WORD_W-BYTE_W-1:BYTE_W]};
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: consumes a header-prefixed byte stream and writes 32-bit words
// to a bram32 port at byte addresses 0x0, 0x4, ..., holding the core until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic                  w_enb,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  words_written,
  output ldr_state_e            dbg_state
);

  localparam int                 CAP_WORDS = 1 << (ADDR_WIDTH - 2);
  localparam logic [CNT_WIDTH:0] CAP       = CAP_WORDS[CNT_WIDTH:0];

  ldr_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  word_idx_q, word_idx_d;
  logic [CNT_WIDTH-1:0]  ww_q, ww_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_dat_q, w_dat_d;
  logic                  w_enb_q, w_enb_d;

  logic                  xfer;
  logic                  pk_clear;
  logic                  pk_valid;
  logic [WORD_W-1:0]     pk_word;
  logic                  pk_full;
  logic [15:0]           hdr_count;
  logic                  in_range;

  // Handshake: a byte moves only on a cycle where s_valid && s_ready; s_ready
  // depends on state alone, never on s_valid, so no combinational loop forms.
  assign s_ready   = ldr_takes_bytes(state_q);
  assign xfer      = s_valid && s_ready;
  assign pk_valid  = xfer && (state_q == LDR_DATA);
  assign hdr_count = {s_data, cnt_q[7:0]};
  assign in_range  = ({1'b0, word_idx_q} < CAP);

  imem_loader_byte_word_packer u_packer (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (s_data),
    .word_o       (pk_word),
    .word_full_o  (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    ww_d       = ww_q;
    ovf_d      = ovf_q;
    w_addr_d   = w_addr_q;
    w_dat_d    = w_dat_q;
    w_enb_d    = 1'b0;
    pk_clear   = 1'b0;
    case (state_q)
      LDR_IDLE, LDR_DONE: begin
        if (start) begin
          state_d    = LDR_LEN_LO;
          cnt_d      = '0;
          word_idx_d = '0;
          ww_d       = '0;
          ovf_d      = 1'b0;
          pk_clear   = 1'b1;
        end
      end
      LDR_LEN_LO: begin
        if (xfer) begin
          cnt_d   = CNT_WIDTH'(s_data);
          state_d = LDR_LEN_HI;
        end
      end
      LDR_LEN_HI: begin
        if (xfer) begin
          cnt_d   = CNT_WIDTH'(hdr_count);
          ovf_d   = ({1'b0, CNT_WIDTH'(hdr_count)} > CAP);
          state_d = (hdr_count == 16'd0) ? LDR_DONE : LDR_DATA;
        end
      end
      LDR_DATA: begin
        if (pk_full) begin
          state_d = LDR_WRITE;
          // Words past capacity are consumed but never written, so w_addr cannot wrap.
          if (in_range) begin
            w_enb_d  = 1'b1;
            w_addr_d = ADDR_WIDTH'({word_idx_q, 2'b00});
            w_dat_d  = DATA_WIDTH'(pk_word);
          end
        end
      end
      LDR_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        if (w_enb_q) ww_d = ww_q + 1'b1;
        state_d = (word_idx_d == cnt_q) ? LDR_DONE : LDR_DATA;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LDR_IDLE;
      cnt_q      <= '0;
      word_idx_q <= '0;
      ww_q       <= '0;
      ovf_q      <= 1'b0;
      w_addr_q   <= '0;
      w_dat_q    <= '0;
      w_enb_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      ww_q       <= ww_d;
      ovf_q      <= ovf_d;
      w_addr_q   <= w_addr_d;
      w_dat_q    <= w_dat_d;
      w_enb_q    <= w_enb_d;
    end
  end

  assign w_addr        = w_addr_q;
  assign w_dat         = w_dat_q;
  assign w_enb         = w_enb_q;
  assign done          = (state_q == LDR_DONE);
  assign cpu_hold      = (state_q != LDR_DONE);
  assign busy          = ldr_is_busy(state_q);
  assign overflow      = ovf_q;
  assign words_written = ww_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default instance plus a 4-word-capacity
// instance for the overflow case; writes are collected and scored in order.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int W = 48;

  logic clk = 1'b0;
  logic rst, start, s_valid, sel;
  logic [7:0] s_data;

  always #5 clk = ~clk;

  logic        start_a, s_valid_a, s_ready_a, w_enb_a, cpu_hold_a, busy_a, done_a, overflow_a;
  logic [9:0]  w_addr_a;
  logic [31:0] w_dat_a;
  logic [15:0] ww_a;
  ldr_state_e  dbg_a;

  logic        start_b, s_valid_b, s_ready_b, w_enb_b, cpu_hold_b, busy_b, done_b, overflow_b;
  logic [3:0]  w_addr_b;
  logic [31:0] w_dat_b;
  logic [15:0] ww_b;
  ldr_state_e  dbg_b;

  assign start_a   = start & ~sel;
  assign s_valid_a = s_valid & ~sel;
  assign start_b   = start & sel;
  assign s_valid_b = s_valid & sel;

  imem_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s_data(s_data), .s_valid(s_valid_a),
    .s_ready(s_ready_a), .w_addr(w_addr_a), .w_dat(w_dat_a), .w_enb(w_enb_a),
    .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .overflow(overflow_a),
    .words_written(ww_a), .dbg_state(dbg_a)
  );

  imem_loader #(.ADDR_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s_data(s_data), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .w_addr(w_addr_b), .w_dat(w_dat_b), .w_enb(w_enb_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .overflow(overflow_b),
    .words_written(ww_b), .dbg_state(dbg_b)
  );

  logic        rdy, enb_sel, done_sel;
  logic [15:0] addr_sel;
  logic [31:0] dat_sel;
  assign rdy      = sel ? s_ready_b : s_ready_a;
  assign enb_sel  = sel ? w_enb_b : w_enb_a;
  assign done_sel = sel ? done_b : done_a;
  assign addr_sel = sel ? 16'(w_addr_b) : 16'(w_addr_a);
  assign dat_sel  = sel ? w_dat_b : w_dat_a;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  bit gaps   = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Collect writes; in the default instance s_ready must drop exactly in write cycles.
  always @(negedge clk) begin
    if (enb_sel) obs_q.push_back({addr_sel, dat_sel});
    if (!sel && busy_a && (s_ready_a == w_enb_a)) viol++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if (gaps && ($urandom_range(0, 1) == 1)) repeat ($urandom_range(1, 3)) step();
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!rdy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) check("byte_accept_timeout", 64'(rdy), 64'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done_sel && t < 40) begin
      step();
      t++;
    end
    check({tag, "_done"}, 64'(done_sel), 64'd1);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_write"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic load_image();
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00400513);
    send_word(32'h0080006f);
    exp_q.push_back({16'h0000, 32'h00400513});
    exp_q.push_back({16'h0004, 32'h0080006f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready_a), 64'd0);
    check("rst_w_enb", 64'(w_enb_a), 64'd0);
    check("rst_w_addr", 64'(w_addr_a), 64'd0);
    check("rst_w_dat", 64'(w_dat_a), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_overflow", 64'(overflow_a), 64'd0);
    check("rst_words", 64'(ww_a), 64'd0);
    rst = 1'b0;
    step();

    // Basic image; the first byte is offered together with start and must survive IDLE.
    start = 1'b1; s_valid = 1'b1; s_data = 8'h02;
    step();
    start = 1'b0;
    check("t1_busy", 64'(busy_a), 64'd1);
    check("t1_hold", 64'(cpu_hold_a), 64'd1);
    load_image();
    wait_done("t1");
    check("t1_words", 64'(ww_a), 64'd2);
    check("t1_hold_released", 64'(cpu_hold_a), 64'd0);
    compare_writes("t1");
    s_valid = 1'b1; s_data = 8'hAA;
    repeat (3) step();
    check("t1_done_not_ready", 64'(s_ready_a), 64'd0);
    check("t1_done_sticky", 64'(done_a), 64'd1);
    s_valid = 1'b0;

    // Empty image.
    pulse_start();
    check("t2_restart_done", 64'(done_a), 64'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t2_done_next_cycle", 64'(done_a), 64'd1);
    check("t2_words", 64'(ww_a), 64'd0);
    repeat (2) step();
    compare_writes("t2");

    // Same image with random stream gaps.
    gaps = 1'b1;
    pulse_start();
    load_image();
    wait_done("t3");
    gaps = 1'b0;
    check("t3_words", 64'(ww_a), 64'd2);
    compare_writes("t3");
    check("t3_ready_vs_write", 64'(viol), 64'd0);

    // Capacity 4 words, header asks for 5.
    sel = 1'b1;
    step();
    pulse_start();
    send_byte(8'h05);
    check("t4_no_ovf_yet", 64'(overflow_b), 64'd0);
    send_byte(8'h00);
    check("t4_overflow", 64'(overflow_b), 64'd1);
    for (int i = 0; i < 5; i++) begin
      send_word(32'hC0DE0000 | 32'(i));
      if (i < 4) exp_q.push_back({16'(i * 4), 32'hC0DE0000 | 32'(i)});
    end
    wait_done("t4");
    check("t4_words", 64'(ww_b), 64'd4);
    check("t4_overflow_sticky", 64'(overflow_b), 64'd1);
    compare_writes("t4");
    sel = 1'b0;
    step();

    // Reset in the middle of the second word.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00400513);
    exp_q.push_back({16'h0000, 32'h00400513});
    send_byte(8'h6f);
    send_byte(8'h00);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 64'(busy_a), 64'd0);
    check("t5_rst_hold", 64'(cpu_hold_a), 64'd1);
    check("t5_rst_w_dat", 64'(w_dat_a), 64'd0);
    check("t5_rst_w_addr", 64'(w_addr_a), 64'd0);
    check("t5_rst_words", 64'(ww_a), 64'd0);
    check("t5_rst_ready", 64'(s_ready_a), 64'd0);
    step();
    rst = 1'b0;
    step();
    pulse_start();
    load_image();
    wait_done("t5");
    check("t5_words", 64'(ww_a), 64'd2);
    compare_writes("t5");

    // start while busy is ignored; start from DONE re-arms.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h05);
    pulse_start();
    send_byte(8'h40);
    send_byte(8'h00);
    send_word(32'h0080006f);
    exp_q.push_back({16'h0000, 32'h00400513});
    exp_q.push_back({16'h0004, 32'h0080006f});
    wait_done("t6");
    check("t6_words", 64'(ww_a), 64'd2);
    compare_writes("t6");
    pulse_start();
    check("t6_rearm_done", 64'(done_a), 64'd0);
    check("t6_rearm_hold", 64'(cpu_hold_a), 64'd1);
    check("t6_rearm_words", 64'(ww_a), 64'd0);
    check("t6_rearm_busy", 64'(busy_a), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
